// File: rtl/ll_fifo_rr_drain_if.sv
// Pop-side and output-stream bundle for the round-robin drain scheduler.
// master = scheduler view, slave = fifo/consumer view.
interface ll_fifo_rr_drain_if #(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
);
  logic [NUM_FIFOS-1:0] empty;
  logic [WIDTH-1:0]     fifo_data;
  logic                 hold;
  logic                 pop;
  logic [SEL_WIDTH-1:0] pop_sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_WIDTH-1:0] out_src;

  modport master (
    input  empty, fifo_data, hold, out_ready,
    output pop, pop_sel, out_valid, out_data, out_src
  );

  modport slave (
    output empty, fifo_data, hold, out_ready,
    input  pop, pop_sel, out_valid, out_data, out_src
  );
endinterface

// File: rtl/ll_fifo_rr_drain.sv
// Weighted round-robin drain of a linked-list fifo bank into a
// 2-entry tagged valid/ready output buffer.
module ll_fifo_rr_drain #(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int BURST     = 2,
  parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1,
  parameter int CNT_WIDTH = $clog2(BURST + 1)
) (
  input  logic               clk,
  input  logic               rst,
  ll_fifo_rr_drain_if.master bus
);

  typedef enum logic {SCAN, STAY} state_e;

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [1:0]           count_q, count_d;
  logic [WIDTH-1:0]     dat_q [2];
  logic [SEL_WIDTH-1:0] src_q [2];
  logic                 wr_q, rd_q;

  logic [SEL_WIDTH-1:0] cand;
  logic [SEL_WIDTH-1:0] idx;
  logic                 found;
  logic                 pop_w;
  logic                 deq;
  logic                 stay_hit;
  logic                 new_grant;
  logic                 stay_drop;

  function automatic logic [SEL_WIDTH-1:0] inc_wrap(
    input logic [SEL_WIDTH-1:0] v
  );
    return (v == SEL_WIDTH'(NUM_FIFOS - 1)) ?
      '0 : v + SEL_WIDTH'(1);
  endfunction

  // First non-empty fifo at or after ptr, wrapping at NUM_FIFOS-1
  always_comb begin
    cand  = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      if (!found && !bus.empty[idx]) begin
        cand  = idx;
        found = 1'b1;
      end
      idx = inc_wrap(idx);
    end
  end

  assign pop_w = !rst && !bus.hold && !count_q[1] && found;
  assign deq   = bus.out_valid && bus.out_ready;

  assign bus.pop       = pop_w;
  assign bus.pop_sel   = cand;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = dat_q[rd_q];
  assign bus.out_src   = src_q[rd_q];

  assign cnt_inc   = cnt_q + CNT_WIDTH'(1);
  assign stay_hit  = pop_w && (state_q == STAY) &&
                     (cand == ptr_q);
  assign new_grant = pop_w && !stay_hit;
  assign stay_drop = !rst && !bus.hold && !pop_w &&
                     (state_q == STAY) && bus.empty[ptr_q];

  // Grant/burst next state; hold leaves everything frozen
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      stay_hit: begin
        if (cnt_inc == CNT_WIDTH'(BURST)) begin
          state_d = SCAN;
          ptr_d   = inc_wrap(ptr_q);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      new_grant: begin
        if (BURST == 1) begin
          state_d = SCAN;
          ptr_d   = inc_wrap(cand);
          cnt_d   = '0;
        end else begin
          state_d = STAY;
          ptr_d   = cand;
          cnt_d   = CNT_WIDTH'(1);
        end
      end
      stay_drop: begin
        state_d = SCAN;
        ptr_d   = inc_wrap(ptr_q);
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  // Grant/burst state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Occupancy: one push per pop, one release per handshake
  always_comb begin
    count_d = count_q + {1'b0, pop_w} - {1'b0, deq};
  end

  // Two-entry output buffer capturing {fifo_data, pop_sel}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        dat_q[i] <= '0;
        src_q[i] <= '0;
      end
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (pop_w) begin
        dat_q[wr_q] <= bus.fifo_data;
        src_q[wr_q] <= cand;
        wr_q        <= ~wr_q;
      end
      if (deq) begin
        rd_q <= ~rd_q;
      end
      count_q <= count_d;
    end
  end

  a_no_empty_pop: assert property (
    @(posedge clk) disable iff (rst)
    !(pop_w && bus.empty[cand]));

  a_count_max: assert property (
    @(posedge clk) disable iff (rst)
    count_q != 2'd3);

  a_no_pop_full: assert property (
    @(posedge clk) disable iff (rst)
    !(pop_w && count_q == 2'd2));

endmodule

// File: tb/tb_ll_fifo_rr_drain.sv
// Bench for ll_fifo_rr_drain: two instances (2 fifos/burst 2 and
// 3 fifos/burst 1) checked every cycle against a queue-based model.
module tb_ll_fifo_rr_drain;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ll_fifo_rr_drain_if #(.WIDTH(8), .NUM_FIFOS(2)) if0 ();
  ll_fifo_rr_drain_if #(.WIDTH(8), .NUM_FIFOS(3)) if1 ();

  ll_fifo_rr_drain #(
    .WIDTH(8), .NUM_FIFOS(2), .BURST(2)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(if0)
  );

  ll_fifo_rr_drain #(
    .WIDTH(8), .NUM_FIFOS(3), .BURST(1)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(if1)
  );

  logic [2:0] empty_v [2];
  logic       hold_v  [2];
  logic       rdy_v   [2];
  logic [7:0] fd_v    [2];

  logic       pop_w [2];
  logic [1:0] sel_w [2];
  logic       ov_w  [2];
  logic [7:0] od_w  [2];
  logic [1:0] os_w  [2];

  assign if0.empty     = empty_v[0][1:0];
  assign if0.hold      = hold_v[0];
  assign if0.out_ready = rdy_v[0];
  assign if0.fifo_data = fd_v[0];
  assign if1.empty     = empty_v[1];
  assign if1.hold      = hold_v[1];
  assign if1.out_ready = rdy_v[1];
  assign if1.fifo_data = fd_v[1];

  assign pop_w[0] = if0.pop;
  assign sel_w[0] = {1'b0, if0.pop_sel};
  assign ov_w[0]  = if0.out_valid;
  assign od_w[0]  = if0.out_data;
  assign os_w[0]  = {1'b0, if0.out_src};
  assign pop_w[1] = if1.pop;
  assign sel_w[1] = if1.pop_sel;
  assign ov_w[1]  = if1.out_valid;
  assign od_w[1]  = if1.out_data;
  assign os_w[1]  = if1.out_src;

  // model: fifo contents, expected buffer, grant owner
  logic [7:0] fq   [6][$];
  logic [9:0] exq  [2][$];
  logic [9:0] olog [2][$];
  int         plog [2][$];
  int         cur  [2];
  int         nxt  [2];
  int         used [2];

  int n_cmp;
  int n_bad;

  function automatic int nf(int d);
    return (d != 0) ? 3 : 2;
  endfunction

  function automatic int bu(int d);
    return (d != 0) ? 1 : 2;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      exq[d].delete();
      olog[d].delete();
      plog[d].delete();
      cur[d]  = -1;
      nxt[d]  = 0;
      used[d] = 0;
    end
    for (int i = 0; i < 6; i++) fq[i].delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      hold_v[d]  = 1'b0;
      rdy_v[d]   = 1'b1;
      fd_v[d]    = 8'h00;
      empty_v[d] = 3'b111;
    end
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one clock: present empties, compare, feed data, advance model
  task automatic step();
    int n, b, start, s, idx;
    bit any, ep, deq, ev;
    logic [9:0] hd;
    for (int d = 0; d < 2; d++) begin
      empty_v[d] = 3'b111;
      for (int i = 0; i < nf(d); i++)
        empty_v[d][i] = (fq[d*3+i].size() == 0);
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      n = nf(d);
      b = bu(d);
      start = (cur[d] >= 0) ? cur[d] : nxt[d];
      any = 1'b0;
      s = start;
      for (int k = 0; k < n; k++) begin
        idx = (start + k) % n;
        if (!any && fq[d*3+idx].size() != 0) begin
          any = 1'b1;
          s = idx;
        end
      end
      ep = !hold_v[d] && (exq[d].size() < 2) && any;
      n_cmp++;
      if (pop_w[d] !== ep) begin
        n_bad++;
        $display("FAIL pop d%0d t=%0t got %b exp %b",
                 d, $time, pop_w[d], ep);
      end
      if (ep) begin
        n_cmp++;
        if (sel_w[d] !== 2'(s)) begin
          n_bad++;
          $display("FAIL pop_sel d%0d t=%0t got %0d exp %0d",
                   d, $time, sel_w[d], s);
        end
      end
      ev = (exq[d].size() != 0);
      n_cmp++;
      if (ov_w[d] !== ev) begin
        n_bad++;
        $display("FAIL out_valid d%0d t=%0t got %b exp %b",
                 d, $time, ov_w[d], ev);
      end
      if (ev) begin
        hd = exq[d][0];
        n_cmp++;
        if ({os_w[d], od_w[d]} !== hd) begin
          n_bad++;
          $display("FAIL head d%0d t=%0t got %h exp %h",
                   d, $time, {os_w[d], od_w[d]}, hd);
        end
      end
      if (ov_w[d] && rdy_v[d])
        olog[d].push_back({os_w[d], od_w[d]});
      deq = ev && rdy_v[d];
      if (deq) void'(exq[d].pop_front());
      if (ep) begin
        fd_v[d] = fq[d*3+s].pop_front();
        exq[d].push_back({2'(s), fd_v[d]});
        plog[d].push_back(s);
        if (cur[d] == s) begin
          used[d]++;
          if (used[d] >= b) begin
            cur[d] = -1;
            nxt[d] = (s + 1) % n;
          end
        end else begin
          used[d] = 1;
          if (b == 1) begin
            cur[d] = -1;
            nxt[d] = (s + 1) % n;
          end else begin
            cur[d] = s;
          end
        end
      end else begin
        fd_v[d] = 8'h00;
        if (!hold_v[d] && cur[d] >= 0 &&
            fq[d*3+cur[d]].size() == 0) begin
          nxt[d] = (cur[d] + 1) % n;
          cur[d] = -1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      hold_v[d]  = 1'b0;
      rdy_v[d]   = 1'b1;
      fd_v[d]    = 8'h00;
      empty_v[d] = 3'b000;
    end
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (pop_w[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_pop d%0d got %b exp 0", d, pop_w[d]);
      end
      n_cmp++;
      if (ov_w[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_valid d%0d got %b exp 0", d, ov_w[d]);
      end
      n_cmp++;
      if ({os_w[d], od_w[d]} !== 10'h000) begin
        n_bad++;
        $display("FAIL rst_head d%0d got %h exp 000",
                 d, {os_w[d], od_w[d]});
      end
    end
    do_reset();
    step();
    step();
  endtask

  task automatic test_single_fifo();
    do_reset();
    fq[0] = '{8'hA1, 8'hA2, 8'hA3};
    for (int c = 0; c < 5; c++) step();
    n_cmp++;
    if (olog[0].size() != 3) begin
      n_bad++;
      $display("FAIL single_cnt got %0d exp 3", olog[0].size());
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (k >= olog[0].size() ||
          olog[0][k] !== {2'd0, 8'(8'hA1 + k)}) begin
        n_bad++;
        $display("FAIL single_data k%0d exp %h",
                 k, {2'd0, 8'(8'hA1 + k)});
      end
    end
  endtask

  task automatic test_two_fifo_burst();
    logic [9:0] ex [6];
    ex = '{10'h0A0, 10'h0A1, 10'h1B0, 10'h1B1, 10'h0A2, 10'h1B2};
    do_reset();
    fq[0] = '{8'hA0, 8'hA1, 8'hA2};
    fq[1] = '{8'hB0, 8'hB1, 8'hB2};
    for (int c = 0; c < 9; c++) step();
    n_cmp++;
    if (olog[0].size() != 6) begin
      n_bad++;
      $display("FAIL burst_cnt got %0d exp 6", olog[0].size());
    end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (k >= olog[0].size() || olog[0][k] !== ex[k]) begin
        n_bad++;
        $display("FAIL burst_order k%0d exp %h", k, ex[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fq[0] = '{8'hC1, 8'hC2, 8'hC3};
    rdy_v[0] = 1'b0;
    for (int c = 0; c < 5; c++) step();
    n_cmp++;
    if (plog[0].size() != 2) begin
      n_bad++;
      $display("FAIL bp_pops got %0d exp 2", plog[0].size());
    end
    rdy_v[0] = 1'b1;
    step();
    n_cmp++;
    if (plog[0].size() != 2) begin
      n_bad++;
      $display("FAIL bp_hs_cycle got %0d exp 2", plog[0].size());
    end
    step();
    n_cmp++;
    if (plog[0].size() != 3) begin
      n_bad++;
      $display("FAIL bp_third got %0d exp 3", plog[0].size());
    end
    for (int c = 0; c < 3; c++) step();
  endtask

  task automatic test_wrap();
    int ex [7];
    ex = '{2, 0, 1, 2, 0, 2, 0};
    do_reset();
    fq[4] = '{8'h11};
    for (int c = 0; c < 3; c++) step();
    plog[1].delete();
    fq[3] = '{8'h20, 8'h21, 8'h22};
    fq[4] = '{8'h30};
    fq[5] = '{8'h40, 8'h41, 8'h42};
    for (int c = 0; c < 7; c++) step();
    n_cmp++;
    if (plog[1].size() != 7) begin
      n_bad++;
      $display("FAIL wrap_cnt got %0d exp 7", plog[1].size());
    end
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (k >= plog[1].size() || plog[1][k] != ex[k]) begin
        n_bad++;
        $display("FAIL wrap_sel k%0d exp %0d", k, ex[k]);
      end
    end
    for (int c = 0; c < 3; c++) step();
  endtask

  task automatic test_hold();
    int ex [6];
    ex = '{0, 0, 1, 1, 0, 0};
    do_reset();
    fq[0] = '{8'h60, 8'h61, 8'h62, 8'h63};
    fq[1] = '{8'h70, 8'h71};
    step();
    hold_v[0] = 1'b1;
    for (int c = 0; c < 3; c++) step();
    n_cmp++;
    if (plog[0].size() != 1) begin
      n_bad++;
      $display("FAIL hold_pops got %0d exp 1", plog[0].size());
    end
    hold_v[0] = 1'b0;
    for (int c = 0; c < 7; c++) step();
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (k >= plog[0].size() || plog[0][k] != ex[k]) begin
        n_bad++;
        $display("FAIL hold_sel k%0d exp %0d", k, ex[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fq[0] = '{8'h81, 8'h82, 8'h83};
    fq[1] = '{8'h91, 8'h92};
    fq[3] = '{8'hD1, 8'hD2, 8'hD3};
    rdy_v[0] = 1'b0;
    rdy_v[1] = 1'b0;
    for (int c = 0; c < 3; c++) step();
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (pop_w[d] !== 1'b0 || ov_w[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL async_rst d%0d pop %b valid %b exp 0 0",
                 d, pop_w[d], ov_w[d]);
      end
    end
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rdy_v[0] = 1'b1;
    rdy_v[1] = 1'b1;
    fq[0] = '{8'h50};
    fq[1] = '{8'h51};
    for (int c = 0; c < 4; c++) step();
    n_cmp++;
    if (plog[0].size() == 0 || plog[0][0] != 0) begin
      n_bad++;
      $display("FAIL post_rst_ptr exp first sel 0");
    end
    n_cmp++;
    if (olog[0].size() == 0 || olog[0][0] !== 10'h050) begin
      n_bad++;
      $display("FAIL post_rst_data exp 050");
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < nf(d); i++)
          if ($urandom_range(0, 9) < 3 && fq[d*3+i].size() < 6)
            fq[d*3+i].push_back(8'($urandom));
        hold_v[d] = ($urandom_range(0, 9) == 0);
        rdy_v[d]  = ($urandom_range(0, 9) < 7);
      end
      step();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      hold_v[d]  = 1'b0;
      rdy_v[d]   = 1'b1;
      fd_v[d]    = 8'h00;
      empty_v[d] = 3'b111;
    end
    model_clear();
    test_reset();
    test_single_fifo();
    test_two_fifo_burst();
    test_backpressure();
    test_wrap();
    test_hold();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
